trajectory_write_arbiter: RTL
=============================

Name: trajectory_write_arbiter

Overview:
- Shares the 512-entry trajectory draw memory write port between NUM_REQ missile-trajectory sources using round-robin arbitration and a req/ack handshake.
- Owns the circular write pointer (0..DEPTH-1) and raises reset_graph when the pointer reaches CLEAR_AT.
- Sequences a full-memory blank sweep on request.
- Sits between the per-missile trajectory generators and the dual-port trajectory memory that the VGA draw logic reads.

Parameters:
- NUM_REQ, 4, number of requesters.
- ADDR_W, 9, memory write-address width.
- DATA_W, 19, pixel memloc width (640x480 linear address).
- DEPTH, 400, number of used memory entries; pointer wraps after DEPTH-1.
- CLEAR_AT, 300, pointer value that triggers the reset_graph pulse.
- BLANK, 19'h7FFFF, value written during a clear sweep (off-screen marker).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req  in  NUM_REQ  per-requester write request; held until ack.
- req_data  in  NUM_REQ*DATA_W  per-requester memloc; requester i occupies bits [i*DATA_W +: DATA_W]; stable while req is high.
- clear_req  in  1  single-cycle pulse; request a blank sweep.
- ack  out  NUM_REQ  one-hot, one-cycle acknowledge.
- mem_wraddress  out  ADDR_W  memory write address.
- mem_data  out  DATA_W  memory write data.
- mem_wren  out  1  memory write enable.
- wr_ptr  out  ADDR_W  next entry to be written.
- reset_graph  out  1  one-cycle pulse.
- busy  out  1  high while in CLEAR.

Behaviour:
- All outputs are registered. Reset values: ack=0, mem_wren=0, mem_wraddress=0, mem_data=0, wr_ptr=0, reset_graph=0, busy=0. State returns to IDLE, the clear-pending flag clears, and the round-robin last-grant resets to NUM_REQ-1, so requester 0 has highest priority.
- FSM has three states: IDLE, WRITE, CLEAR.
- IDLE:
  - If clear-pending or clear_req is set, go to CLEAR. Set busy=1 and the sweep address to 0.
  - Otherwise, if any req is high, pick the first requesting index after last-grant, modulo NUM_REQ. Latch its index and data, update last-grant, and go to WRITE.
  - Otherwise, stay in IDLE.
- WRITE (exactly 1 cycle):
  - mem_wren=1, mem_wraddress=wr_ptr, mem_data=latched data, ack[grant]=1.
  - wr_ptr becomes wr_ptr+1, or 0 if wr_ptr==DEPTH-1.
  - Go to IDLE.
  - Throughput is one write per 2 cycles. Latency from req sampled high in IDLE to ack is 1 cycle.
- Handshake: the requester drops req, or presents new data, on the edge where it samples ack=1. The arbiter never samples a stale req.
- reset_graph pulses for one cycle, on the cycle after the WRITE that moves wr_ptr to CLEAR_AT. Wrap-around to 0 produces no pulse.
- CLEAR:
  - Each cycle: mem_wren=1, mem_wraddress=sweep address, mem_data=BLANK, then increment the sweep address.
  - After writing DEPTH-1: wr_ptr=0, busy=0, clear-pending=0, go to IDLE.
  - Duration is exactly DEPTH cycles. ack stays 0 and reqs wait.
- clear_req arriving in WRITE sets clear-pending, which is serviced at the next IDLE ahead of any req. clear_req during CLEAR is ignored.
- Asynchronous reset mid-WRITE or mid-CLEAR aborts immediately with reset values. A partial sweep is not resumed.
- Widths: wr_ptr and the sweep counter are ADDR_W bits. DEPTH must be ≤ 2**ADDR_W, and CLEAR_AT must be < DEPTH.

Optional Feature:
- Macro: TRAJ_DEDUP_EN.
- Defined:
  - Each requester keeps a last-written DATA_W register plus a valid bit.
  - In WRITE, if the valid bit is set and the latched data equals the last-written value, ack still pulses but mem_wren=0, wr_ptr holds, and reset_graph is not triggered.
  - Otherwise the write proceeds normally and the register is updated.
  - Valid bits clear on reset and on CLEAR completion.
- Undefined: every granted request writes; no per-requester registers exist.

Test Plan:
- Reset, then req[2]=1 with data 19'd1234 → ack[2] one cycle later, with mem_wren=1, mem_wraddress=0, mem_data=1234; then wr_ptr=1.
- req[0..3] all held high and re-asserted after each ack → grants in order 0,1,2,3,0, one write every 2 cycles, addresses 0..4.
- Drive 400 single writes from req[1] → reset_graph pulses once, the cycle after the write to address 299. The write after address 399 goes to address 0 with no pulse.
- clear_req pulse during WRITE while req[3] is pending → the WRITE completes, then busy=1 for 400 cycles writing 19'h7FFFF to 0..399. ack[3] follows only after busy falls, written to address 0.
- Assert reset at sweep address 150 → all outputs 0 immediately and state IDLE. A following req[0] writes to address 0.
- With TRAJ_DEDUP_EN: req[1] sends 500, then 500 again → second ack has mem_wren=0 and wr_ptr unchanged at 1. Then 501 → write to address 1.

Source files
------------

// File: rtl/trajectory_write_arbiter.sv
// trajectory_write_arbiter: round-robin trajectory memory write arbiter with pointer, graph reset and blank sweep; TRAJ_DEDUP_EN skips repeated writes
module trajectory_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 19,
  parameter int DEPTH = 400,
  parameter int CLEAR_AT = 300,
  parameter logic [DATA_W-1:0] BLANK = 19'h7FFFF
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic                        clear_req,
  output logic [NUM_REQ-1:0]          ack,
  output logic [ADDR_W-1:0]           mem_wraddress,
  output logic [DATA_W-1:0]           mem_data,
  output logic                        mem_wren,
  output logic [ADDR_W-1:0]           wr_ptr,
  output logic                        reset_graph,
  output logic                        busy
);
  localparam int GW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;
  state_t state, state_n;
  logic pend, pend_n, dup, sweep_done, wren_n, rg_n, busy_n;
  logic [GW-1:0] last, last_n, pick, cand;
  logic [DATA_W-1:0] pick_data, data_n;
  logic [NUM_REQ-1:0] ack_n;
  logic [ADDR_W-1:0] addr_n, ptr_n;
  assign pick_data = req_data[pick*DATA_W +: DATA_W];
  assign sweep_done = state == CLEAR && mem_wraddress == ADDR_W'(DEPTH - 1);
`ifdef TRAJ_DEDUP_EN
  logic take;
  logic [DATA_W-1:0] last_val [NUM_REQ];
  logic [NUM_REQ-1:0] last_vld;
  assign take = state == IDLE && !(pend || clear_req) && |req;
  assign dup = last_vld[pick] && last_val[pick] == pick_data;
  // per-requester memory of the last value actually written
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      last_vld <= '0;
      last_val <= '{default: '0};
    end else if (sweep_done) last_vld <= '0;
    else if (take && !dup) begin
      last_vld[pick] <= 1'b1;
      last_val[pick] <= pick_data;
    end
`else
  assign dup = 1'b0;
`endif
  // first requester after the last grant, scanning farthest-first so the nearest wins
  always_comb begin
    pick = last;
    cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = GW'((int'(last) + k) % NUM_REQ);
      if (req[cand]) pick = cand;
    end
  end
  // next-state and next registered outputs
  always_comb begin
    state_n = state;
    pend_n = pend;
    last_n = last;
    ptr_n = wr_ptr;
    ack_n = '0;
    wren_n = 1'b0;
    addr_n = mem_wraddress;
    data_n = mem_data;
    rg_n = 1'b0;
    busy_n = busy;
    case (state)
      IDLE:
        if (pend || clear_req) begin
          state_n = CLEAR;
          busy_n = 1'b1;
          wren_n = 1'b1;
          addr_n = '0;
          data_n = BLANK;
        end else if (|req) begin
          state_n = WRITE;
          last_n = pick;
          ack_n[pick] = 1'b1;
          wren_n = !dup;
          addr_n = wr_ptr;
          data_n = pick_data;
        end
      WRITE: begin
        state_n = IDLE;
        pend_n = pend || clear_req;
        if (mem_wren) begin
          ptr_n = wr_ptr == ADDR_W'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
          rg_n = ptr_n == ADDR_W'(CLEAR_AT);
        end
      end
      CLEAR:
        if (sweep_done) begin
          state_n = IDLE;
          busy_n = 1'b0;
          pend_n = 1'b0;
          ptr_n = '0;
        end else begin
          wren_n = 1'b1;
          addr_n = mem_wraddress + 1'b1;
        end
      default: state_n = IDLE;
    endcase
  end
  // state and output registers
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      pend <= 1'b0;
      last <= GW'(NUM_REQ - 1);
      wr_ptr <= '0;
      ack <= '0;
      mem_wren <= 1'b0;
      mem_wraddress <= '0;
      mem_data <= '0;
      reset_graph <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      pend <= pend_n;
      last <= last_n;
      wr_ptr <= ptr_n;
      ack <= ack_n;
      mem_wren <= wren_n;
      mem_wraddress <= addr_n;
      mem_data <= data_n;
      reset_graph <= rg_n;
      busy <= busy_n;
    end
endmodule
